operand_issue: RTL
==================

Name: operand_issue

Overview:
- Operand-fetch/issue stage wrapped around the 32x64 register file.
- Drives the regfile read addresses from the decoded instruction and captures the two read operands into an output pipeline register.
- Holds a per-register pending-write scoreboard and stalls on RAW/WAW hazards.
- Issues to execute over a valid/ready handshake. The writeback port is shared with the regfile write port.

Parameters:
- DATA_W, 64, operand/writeback data width.
- NREG, 32, architectural register count; index width is log2(NREG).
- ZERO_REG, 31, hardwired-zero register index; never pending, never bypassed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- in_rn  in  5  source register 1 index.
- in_rm  in  5  source register 2 index.
- in_rd  in  5  destination index.
- in_uses_rn  in  1  rn is read.
- in_uses_rm  in  1  rm is read.
- in_writes_rd  in  1  instruction writes rd.
- rf_rreg1  out  5  regfile ReadRegister1 (= in_rn, combinational).
- rf_rreg2  out  5  regfile ReadRegister2 (= in_rm, combinational).
- rf_rdata1  in  DATA_W  regfile ReadData1.
- rf_rdata2  in  DATA_W  regfile ReadData2.
- wb_valid  in  1  writeback this cycle (same signal as RegWrite).
- wb_reg  in  5  writeback index.
- wb_data  in  DATA_W  writeback data.
- flush  in  1  kill output-register entry and block intake this cycle.
- out_valid  out  1  issued instruction valid.
- out_ready  in  1  execute accepts.
- out_op1  out  DATA_W  registered operand 1.
- out_op2  out  DATA_W  registered operand 2.
- out_rd  out  5  registered destination.
- out_writes_rd  out  1  registered write flag.

Behaviour:
- Reset (async, reset=0):
  - out_valid=0, out_op1=0, out_op2=0, out_rd=ZERO_REG, out_writes_rd=0.
  - All pending bits 0.
  - in_ready=0 while reset is asserted.
- Scoreboard: pending[0..NREG-2]; pending[ZERO_REG] is constant 0.
- Hazard is asserted when any of the following holds:
  - in_uses_rn && pending[in_rn] && !resolved(in_rn)
  - in_uses_rm && pending[in_rm] && !resolved(in_rm)
  - in_writes_rd && pending[in_rd]
- resolved(r) is 1 only with the feature enabled and wb_valid && wb_reg==r. Otherwise it is 0.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Issue occurs on in_valid && in_ready, with 1-cycle latency:
  - The output register loads the operands, rd and writes_rd; out_valid=1 the next cycle.
  - pending[in_rd] is set if in_writes_rd && in_rd!=ZERO_REG.
- Operand select for each source: feature-enabled bypass (see below); else rf_rdata; the ZERO_REG index yields 0.
- Drain: out_ready && out_valid with no new issue -> out_valid=0. Operand registers hold their last value.
- Backpressure: out_valid && !out_ready -> all output fields hold stable and in_ready=0.
- Writeback: wb_valid clears pending[wb_reg] at the edge. wb_reg==ZERO_REG is ignored.
- Same-cycle set and clear of the same index: set wins (new writer). This cannot occur through the hazard rules, but RTL must still prioritise set.
- Flush:
  - At the edge, out_valid becomes 0.
  - If out_valid && out_writes_rd, pending[out_rd] is cleared (its writeback will never arrive).
  - No issue happens in a flush cycle.
  - flush with out_valid=0 only blocks intake.
- Upstream guarantee: no writeback ever targets a non-pending register other than the ZERO_REG.

Optional Feature:
- Macro: PEPE_WB_BYPASS_EN.
- Defined: a source matching wb_reg with wb_valid takes wb_data in the same cycle and does not stall. This covers the regfile read-before-write window.
- Undefined: no bypass path; the consumer stalls until the cycle after writeback, when pending is clear and the regfile returns the new value. This costs one extra stall cycle per RAW dependency.

Decomposition:
- Shared package pepe_pkg:
  - reg_idx_t (5-bit), data_t (64-bit).
  - ZERO_REG=31, NREG=32.
- One sub-module, scoreboard:
  - Pending bit array, set/clear/flush-clear ports, two source lookups plus one destination lookup.
  - Same async active-low reset.

Test Plan:
- Reset mid-operation with out_valid=1, pending[3]=1 -> out_valid=0, out_rd=31, all pending=0 immediately without a clock edge; in_ready=0 until release.
- Issue ADD X3<-X1,X2 with rf_rdata1=5, rf_rdata2=7, out_ready=1 -> next cycle out_valid=1, out_op1=5, out_op2=7, out_rd=3, pending[3]=1.
- RAW: after the previous step, issue SUB X4<-X3,X1; wb X3=0x2A arrives 3 cycles later:
  - Bypass enabled: issues in the wb cycle with out_op1=0x2A.
  - Bypass disabled: issues one cycle later with out_op1=0x2A from the regfile.
- X31 destination/source: in_rd=31, in_writes_rd=1, then in_rn=31 -> no pending set, no stall, out_op1=0 even with wb_reg=31, wb_data=0xFF.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, output fields stable; out_ready=1 -> next instruction issues the following cycle.
- Flush with out_valid=1, out_rd=9, out_writes_rd=1 -> out_valid=0, pending[9]=0; a subsequent reader of X9 issues without stall.

Source files
------------

// File: rtl/pepe_pkg.sv
// Shared types and sizing for the operand-issue stage and its scoreboard.
package pepe_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = $clog2(NREG);
    localparam int unsigned ZERO_REG  = 31;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

endpackage

// File: rtl/operand_issue_scoreboard.sv
// Per-register pending-write bits with set, writeback-clear and flush-clear ports.
module operand_issue_scoreboard
    import pepe_pkg::*;
#(
    parameter int unsigned NReg    = NREG,
    parameter int unsigned ZeroReg = ZERO_REG
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    set_i,
    input  logic [$clog2(NReg)-1:0] set_idx_i,
    input  logic                    clr_i,
    input  logic [$clog2(NReg)-1:0] clr_idx_i,
    input  logic                    fclr_i,
    input  logic [$clog2(NReg)-1:0] fclr_idx_i,
    input  logic [$clog2(NReg)-1:0] rn_idx_i,
    input  logic [$clog2(NReg)-1:0] rm_idx_i,
    input  logic [$clog2(NReg)-1:0] rd_idx_i,
    output logic                    rn_pend_o,
    output logic                    rm_pend_o,
    output logic                    rd_pend_o
);

    localparam int unsigned IdxW = $clog2(NReg);
    localparam logic [IdxW-1:0] ZeroIdx = IdxW'(ZeroReg);

    logic [NReg-1:0] pending_q, pending_d;

    // Set is applied last so a new writer wins over a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (fclr_i) begin
            pending_d[fclr_idx_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_idx_i] = 1'b1;
        end
        pending_d[ZeroIdx] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rn_pend_o = pending_q[rn_idx_i];
    assign rm_pend_o = pending_q[rm_idx_i];
    assign rd_pend_o = pending_q[rd_idx_i];

endmodule

// File: rtl/operand_issue.sv
// Operand fetch/issue stage: regfile read, RAW/WAW stall, registered valid/ready issue.
// Define PEPE_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module operand_issue
    import pepe_pkg::*;
#(
    parameter int unsigned DataW   = DATA_W,
    parameter int unsigned NReg    = NREG,
    parameter int unsigned ZeroReg = ZERO_REG
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [$clog2(NReg)-1:0] in_rn_i,
    input  logic [$clog2(NReg)-1:0] in_rm_i,
    input  logic [$clog2(NReg)-1:0] in_rd_i,
    input  logic                    in_uses_rn_i,
    input  logic                    in_uses_rm_i,
    input  logic                    in_writes_rd_i,
    output logic [$clog2(NReg)-1:0] rf_rreg1_o,
    output logic [$clog2(NReg)-1:0] rf_rreg2_o,
    input  logic [DataW-1:0]        rf_rdata1_i,
    input  logic [DataW-1:0]        rf_rdata2_i,
    input  logic                    wb_valid_i,
    input  logic [$clog2(NReg)-1:0] wb_reg_i,
    input  logic [DataW-1:0]        wb_data_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DataW-1:0]        out_op1_o,
    output logic [DataW-1:0]        out_op2_o,
    output logic [$clog2(NReg)-1:0] out_rd_o,
    output logic                    out_writes_rd_o
);

    localparam int unsigned IdxW = $clog2(NReg);
    localparam logic [IdxW-1:0] ZeroIdx = IdxW'(ZeroReg);

    logic            rn_pend, rm_pend, rd_pend;
    logic            rn_res, rm_res;
    logic            hazard, issue, set_en, fclr_en;
    logic [DataW-1:0] op1_sel, op2_sel;

    logic            out_valid_q, out_valid_d;
    logic [DataW-1:0] out_op1_q, out_op1_d;
    logic [DataW-1:0] out_op2_q, out_op2_d;
    logic [IdxW-1:0] out_rd_q, out_rd_d;
    logic            out_writes_rd_q, out_writes_rd_d;

    assign rf_rreg1_o = in_rn_i;
    assign rf_rreg2_o = in_rm_i;

`ifdef PEPE_WB_BYPASS_EN
    assign rn_res = wb_valid_i && (wb_reg_i == in_rn_i) && (in_rn_i != ZeroIdx);
    assign rm_res = wb_valid_i && (wb_reg_i == in_rm_i) && (in_rm_i != ZeroIdx);
`else
    assign rn_res = 1'b0;
    assign rm_res = 1'b0;
`endif

    // Zero register overrides both the bypass and the regfile value.
    always_comb begin
        op1_sel = rn_res ? wb_data_i : rf_rdata1_i;
        op2_sel = rm_res ? wb_data_i : rf_rdata2_i;
        if (in_rn_i == ZeroIdx) begin
            op1_sel = '0;
        end
        if (in_rm_i == ZeroIdx) begin
            op2_sel = '0;
        end
    end

    assign hazard = (in_uses_rn_i && rn_pend && !rn_res)
                 || (in_uses_rm_i && rm_pend && !rm_res)
                 || (in_writes_rd_i && rd_pend);

    assign in_ready_o = rst_ni && !hazard && !flush_i && (!out_valid_q || out_ready_i);
    assign issue      = in_valid_i && in_ready_o;
    assign set_en     = issue && in_writes_rd_i && (in_rd_i != ZeroIdx);
    // A flushed writer's writeback never arrives, so release its destination.
    assign fclr_en    = flush_i && out_valid_q && out_writes_rd_q;

    always_comb begin
        out_valid_d     = out_valid_q;
        out_op1_d       = out_op1_q;
        out_op2_d       = out_op2_q;
        out_rd_d        = out_rd_q;
        out_writes_rd_d = out_writes_rd_q;
        if (issue) begin
            out_valid_d     = 1'b1;
            out_op1_d       = op1_sel;
            out_op2_d       = op2_sel;
            out_rd_d        = in_rd_i;
            out_writes_rd_d = in_writes_rd_i;
        end else if (flush_i || out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q     <= 1'b0;
            out_op1_q       <= '0;
            out_op2_q       <= '0;
            out_rd_q        <= ZeroIdx;
            out_writes_rd_q <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_op1_q       <= out_op1_d;
            out_op2_q       <= out_op2_d;
            out_rd_q        <= out_rd_d;
            out_writes_rd_q <= out_writes_rd_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_op1_o       = out_op1_q;
    assign out_op2_o       = out_op2_q;
    assign out_rd_o        = out_rd_q;
    assign out_writes_rd_o = out_writes_rd_q;

    operand_issue_scoreboard #(
        .NReg    (NReg),
        .ZeroReg (ZeroReg)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (set_en),
        .set_idx_i  (in_rd_i),
        .clr_i      (wb_valid_i),
        .clr_idx_i  (wb_reg_i),
        .fclr_i     (fclr_en),
        .fclr_idx_i (out_rd_q),
        .rn_idx_i   (in_rn_i),
        .rm_idx_i   (in_rm_i),
        .rd_idx_i   (in_rd_i),
        .rn_pend_o  (rn_pend),
        .rm_pend_o  (rm_pend),
        .rd_pend_o  (rd_pend)
    );

endmodule
